melody_sequencer: RTL and testbench

//  Song-playback stage that drives the note/octave inputs of the tone generator.
//  - Steps through a melody ROM at a fixed tempo.
//  - Presents each entry's note/octave for its duration, plus a gate that the top ANDs with speaker.
//  - Supports start/stop pulses and optional looping at the end-of-song marker.

---
 rtl/music_pkg.sv | 42 ++++
 rtl/tempo_tick.sv | 31 +++
 rtl/melody_sequencer.sv | 132 +++++++++++++
 tb/tb_melody_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared definitions for the melody playback path: note codes, ROM entry layout, FSM states.
// Pure declarations; no clocked logic.
package music_pkg;

    localparam int TICK_CYCLES_DEF = 390625;
    localparam int ADDR_W_DEF      = 8;

    typedef enum logic [3:0] {
        NOTE_C  = 4'd0,  NOTE_CS = 4'd1,  NOTE_D  = 4'd2,  NOTE_DS = 4'd3,
        NOTE_E  = 4'd4,  NOTE_F  = 4'd5,  NOTE_FS = 4'd6,  NOTE_G  = 4'd7,
        NOTE_GS = 4'd8,  NOTE_A  = 4'd9,  NOTE_AS = 4'd10, NOTE_B  = 4'd11
    } note_t;

    localparam logic [3:0] NOTE_MAX = 4'(NOTE_B);
    localparam logic [2:0] OCT_MAX  = 3'd5;

    localparam int ENT_REST_BIT = 15;
    localparam int ENT_OCT_LSB  = 12;
    localparam int ENT_NOTE_LSB = 8;
    localparam int ENT_DUR_LSB  = 0;

    typedef struct packed {
        logic       rest;
        logic [2:0] octave;
        logic [3:0] note;
        logic [7:0] dur;
    } entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_LOAD,
        ST_PLAY
    } state_t;

    // Out-of-range pitches are played as rests so the tone generator never sees them gated on.
    function automatic logic entry_audible(input entry_t e);
        return !e.rest && (e.note <= NOTE_MAX) && (e.octave <= OCT_MAX);
    endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tempo prescaler: counts enabled cycles 0..TICK_CYCLES-1, tick is high combinationally on the last count.
// Zero latency from count to tick; no backpressure, clear has priority over enable.
module tempo_tick #(
    parameter int TICK_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign tick = en && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en) begin
            if (cnt_q == LAST) cnt_q <= '0;
            else               cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Walks a synchronous melody ROM and drives note/octave/gate for the tone generator.
// First gate 3 cycles after start, 3-cycle gap between notes; no backpressure, stop beats start.
module melody_sequencer
    import music_pkg::*;
#(
    parameter int TICK_CYCLES = TICK_CYCLES_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [3:0]        note,
    output logic [2:0]        octave,
    output logic              gate,
    output logic              busy,
    output logic              done
);

    state_t            state_q, state_d;
    entry_t            ent;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        note_q;
    logic [2:0]        oct_q;
    logic              gate_q;
    logic              done_q;
    logic [7:0]        dur_q;
    logic [7:0]        dur_cnt_q;
    logic              tick;
    logic              last_dur;
    logic              end_mark;

    assign ent      = entry_t'(rom_data);
    assign end_mark = (ent.dur == 8'd0);
    assign last_dur = (dur_cnt_q == dur_q - 8'd1);

    tempo_tick #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tempo_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state_q == ST_LOAD),
        .en   (state_q == ST_PLAY),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_FETCH;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT:  state_d = ST_LOAD;
                ST_LOAD: begin
                    if (end_mark) state_d = loop ? ST_FETCH : ST_IDLE;
                    else          state_d = ST_PLAY;
                end
                ST_PLAY:  if (tick && last_dur) state_d = ST_FETCH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            note_q    <= '0;
            oct_q     <= '0;
            gate_q    <= 1'b0;
            done_q    <= 1'b0;
            dur_q     <= '0;
            dur_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                gate_q <= 1'b0;
            end else if (start) begin
                addr_q <= '0;
                gate_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (end_mark) begin
                            addr_q <= '0;
                            gate_q <= 1'b0;
                            done_q <= !loop;
                        end else begin
                            note_q    <= ent.note;
                            oct_q     <= ent.octave;
                            gate_q    <= entry_audible(ent);
                            dur_q     <= ent.dur;
                            dur_cnt_q <= '0;
                        end
                    end
                    ST_PLAY: begin
                        if (tick) begin
                            if (last_dur) begin
                                // Address wraps silently; only a dur==0 entry ends the song.
                                addr_q <= addr_q + ADDR_W'(1);
                                if (dur_q >= 8'd2) gate_q <= 1'b0;
                            end else begin
                                dur_cnt_q <= dur_cnt_q + 8'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Articulation gap: the final tick of a multi-tick note is silent.
    assign gate     = gate_q && !((state_q == ST_PLAY) && (dur_q >= 8'd2) && last_dur);
    assign rom_addr = addr_q;
    assign note     = note_q;
    assign octave   = oct_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with a 4-cycle tick and a behavioural 1-cycle ROM.
module tb_melody_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        loop;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [3:0]  note;
    logic [2:0]  octave;
    logic        gate;
    logic        busy;
    logic        done;

    logic [15:0] mem [0:255];

    int checks;
    int failures;

    melody_sequencer #(
        .TICK_CYCLES(4),
        .ADDR_W     (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop    (loop),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .note    (note),
        .octave  (octave),
        .gate    (gate),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step(1);
        stop = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({rom_addr, note, octave, gate, busy, done} !== 18'h0) begin
            failures++;
            $display("FAIL reset_in: got addr=%0h note=%0h oct=%0h gate=%b busy=%b done=%b want all 0",
                     rom_addr, note, octave, gate, busy, done);
        end
        rst_n = 1'b1;
        step(3);
        checks++;
        if ({busy, gate, done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_after: got busy=%b gate=%b done=%b want 000", busy, gate, done);
        end
    endtask

    task automatic test_single_note();
        logic exp_g;
        clear_mem();
        mem[0] = 16'h4904;
        loop = 1'b0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || rom_addr !== 8'd0 || gate !== 1'b0) begin
            failures++;
            $display("FAIL t1_fetch: got busy=%b addr=%0h gate=%b want 1 0 0", busy, rom_addr, gate);
        end
        step(2);
        checks++;
        if (gate !== 1'b0) begin
            failures++;
            $display("FAIL t1_load_gate: got %b want 0", gate);
        end
        for (int i = 0; i < 16; i++) begin
            step(1);
            exp_g = (i < 12);
            checks++;
            if (gate !== exp_g || note !== 4'd9 || octave !== 3'd4) begin
                failures++;
                $display("FAIL t1_play cyc%0d: got gate=%b note=%0d oct=%0d want gate=%b note=9 oct=4",
                         i, gate, note, octave, exp_g);
            end
        end
        step(1);
        checks++;
        if (rom_addr !== 8'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t1_next_fetch: got addr=%0h busy=%b want 1 1", rom_addr, busy);
        end
        step(2);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL t1_done_early: got %b want 0", done);
        end
        step(1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || gate !== 1'b0) begin
            failures++;
            $display("FAIL t1_done: got done=%b busy=%b gate=%b want 1 0 0", done, busy, gate);
        end
        step(1);
        checks++;
        if (done !== 1'b0 || note !== 4'd9 || octave !== 3'd4) begin
            failures++;
            $display("FAIL t1_idle_hold: got done=%b note=%0d oct=%0d want 0 9 4", done, note, octave);
        end
    endtask

    task automatic test_rest();
        clear_mem();
        mem[0] = 16'h8402;
        pulse_start();
        step(2);
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++;
            if (gate !== 1'b0 || note !== 4'd4 || octave !== 3'd0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL t2_rest cyc%0d: got gate=%b note=%0d oct=%0d busy=%b want 0 4 0 1",
                         i, gate, note, octave, busy);
            end
        end
        step(4);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t2_done: got done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_loop();
        logic exp_g;
        clear_mem();
        mem[0] = 16'h1302;
        mem[1] = 16'h2501;
        loop = 1'b1;
        pulse_start();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (rom_addr !== 8'd0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL t3_addr0 pass%0d: got addr=%0h busy=%b want 0 1", p, rom_addr, busy);
            end
            step(2);
            for (int i = 0; i < 8; i++) begin
                step(1);
                exp_g = (i < 4);
                checks++;
                if (gate !== exp_g || note !== 4'd3 || octave !== 3'd1) begin
                    failures++;
                    $display("FAIL t3_n0 pass%0d cyc%0d: got gate=%b note=%0d oct=%0d want %b 3 1",
                             p, i, gate, note, octave, exp_g);
                end
            end
            step(1);
            checks++;
            if (rom_addr !== 8'd1) begin
                failures++;
                $display("FAIL t3_addr1 pass%0d: got %0h want 1", p, rom_addr);
            end
            step(2);
            for (int i = 0; i < 4; i++) begin
                step(1);
                checks++;
                if (gate !== 1'b1 || note !== 4'd5 || octave !== 3'd2) begin
                    failures++;
                    $display("FAIL t3_n1 pass%0d cyc%0d: got gate=%b note=%0d oct=%0d want 1 5 2",
                             p, i, gate, note, octave);
                end
            end
            step(1);
            checks++;
            if (rom_addr !== 8'd2) begin
                failures++;
                $display("FAIL t3_addr2 pass%0d: got %0h want 2", p, rom_addr);
            end
            step(3);
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL t3_wrap pass%0d: got done=%b busy=%b want 0 1", p, done, busy);
            end
        end
        pulse_stop();
        loop = 1'b0;
        checks++;
        if (busy !== 1'b0 || gate !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL t3_stop: got busy=%b gate=%b done=%b want 000", busy, gate, done);
        end
    endtask

    task automatic test_stop_restart();
        clear_mem();
        mem[0] = 16'h2701;
        mem[1] = 16'h4904;
        pulse_start();
        step(6);
        step(1);
        checks++;
        if (rom_addr !== 8'd1) begin
            failures++;
            $display("FAIL t4_addr1: got %0h want 1", rom_addr);
        end
        step(5);
        checks++;
        if (gate !== 1'b1 || note !== 4'd9) begin
            failures++;
            $display("FAIL t4_playing: got gate=%b note=%0d want 1 9", gate, note);
        end
        pulse_stop();
        checks++;
        if (gate !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL t4_stop: got gate=%b busy=%b done=%b want 000", gate, busy, done);
        end
        step(4);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL t4_stay_idle: got busy=%b done=%b want 00", busy, done);
        end
        pulse_start();
        checks++;
        if (rom_addr !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t4_restart_addr: got addr=%0h busy=%b want 0 1", rom_addr, busy);
        end
        step(3);
        checks++;
        if (gate !== 1'b1 || note !== 4'd7 || octave !== 3'd2) begin
            failures++;
            $display("FAIL t4_restart_play: got gate=%b note=%0d oct=%0d want 1 7 2", gate, note, octave);
        end
        pulse_start();
        checks++;
        if (gate !== 1'b0 || rom_addr !== 8'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t4_start_busy: got gate=%b addr=%0h busy=%b want 0 0 1", gate, rom_addr, busy);
        end
        step(3);
        checks++;
        if (gate !== 1'b1 || note !== 4'd7) begin
            failures++;
            $display("FAIL t4_replay: got gate=%b note=%0d want 1 7", gate, note);
        end
        start = 1'b1;
        stop  = 1'b1;
        step(1);
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || gate !== 1'b0) begin
            failures++;
            $display("FAIL t4_stop_beats_start: got busy=%b gate=%b want 0 0", busy, gate);
        end
    endtask

    task automatic test_invalid();
        clear_mem();
        mem[0] = 16'h3D01;
        mem[1] = 16'h7202;
        pulse_start();
        step(2);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checks++;
            if (gate !== 1'b0 || note !== 4'd13 || octave !== 3'd3) begin
                failures++;
                $display("FAIL t5_bad_note cyc%0d: got gate=%b note=%0d oct=%0d want 0 13 3",
                         i, gate, note, octave);
            end
        end
        step(1);
        checks++;
        if (rom_addr !== 8'd1) begin
            failures++;
            $display("FAIL t5_addr1: got %0h want 1", rom_addr);
        end
        step(2);
        for (int i = 0; i < 8; i++) begin
            step(1);
            checks++;
            if (gate !== 1'b0 || note !== 4'd2 || octave !== 3'd7) begin
                failures++;
                $display("FAIL t5_bad_oct cyc%0d: got gate=%b note=%0d oct=%0d want 0 2 7",
                         i, gate, note, octave);
            end
        end
        step(4);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL t5_done: got done=%b busy=%b want 1 0", done, busy);
        end
    endtask

    task automatic test_async_reset();
        clear_mem();
        mem[0] = 16'h4904;
        pulse_start();
        step(5);
        checks++;
        if (gate !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL t6_pre: got gate=%b busy=%b want 1 1", gate, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rom_addr, note, octave, gate, busy, done} !== 18'h0) begin
            failures++;
            $display("FAIL t6_async: got addr=%0h note=%0h oct=%0h gate=%b busy=%b done=%b want all 0",
                     rom_addr, note, octave, gate, busy, done);
        end
        step(2);
        rst_n = 1'b1;
        step(5);
        checks++;
        if (busy !== 1'b0 || gate !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL t6_idle: got busy=%b gate=%b done=%b want 000", busy, gate, done);
        end
        pulse_start();
        step(3);
        checks++;
        if (gate !== 1'b1 || note !== 4'd9 || octave !== 3'd4) begin
            failures++;
            $display("FAIL t6_replay: got gate=%b note=%0d oct=%0d want 1 9 4", gate, note, octave);
        end
        pulse_stop();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        loop     = 1'b0;
        clear_mem();
        test_reset();
        test_single_note();
        test_rest();
        test_loop();
        test_stop_restart();
        test_invalid();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
